// File: rtl/ex_mdu_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer.
//   - MDU operation encodings (MULT/MULTU/DIV/DIVU)
//   - Sequencer FSM state encoding
//   - Pipeline stall bus geometry and Stop/NoStop levels
package ex_mdu_ctrl_pkg;

    localparam int unsigned StallW  = 6;  // stall bus width, one bit per pipeline stage
    localparam int unsigned StallEx = 2;  // bit index of the EX stage in the stall bus

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // MULT and DIV are the signed flavours (even encodings).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative datapath: shift-add multiplier / restoring divider on a 2*XLEN accumulator.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load magnitudes op_a (into accumulator low half) and op_b
//   step      : perform one iteration this cycle
//   is_div    : 1 = restoring divide step, 0 = shift-add multiply step
//   op_a/op_b : unsigned magnitudes (multiplicand/dividend, multiplier/divisor)
//   acc_nxt   : accumulator value after this cycle's iteration
//               (multiply: product; divide: {remainder, quotient})
module mdu_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic [2*XLEN-1:0] acc_nxt
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;

    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] div_step;

    always_comb begin
        // Multiply: conditionally add b into the high half, then shift right, keeping the carry.
        add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
        mul_step = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

        // Divide: shift next dividend bit into the partial remainder; the extra top bit
        // covers the case where the shifted remainder exceeds XLEN bits.
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_ge   = rem_sh >= {1'b0, b_q};
        rem_sub  = rem_sh[XLEN-1:0] - b_q;
        div_step = rem_ge ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                          : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

        acc_nxt = is_div ? div_step : mul_step;

        acc_d = acc_q;
        b_d   = b_q;
        if (load) begin
            acc_d = {{XLEN{1'b0}}, op_a};
            b_d   = op_b;
        end else if (step) begin
            acc_d = acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

endmodule

// File: rtl/ex_mdu_ctrl.sv
// EX-stage multi-cycle multiply/divide sequencer (IDLE -> BUSY -> DONE -> IDLE).
//   clk, rst   : clock, synchronous active-high reset
//   stall      : pipeline stall vector; stall[StallEx] = Stop holds the instruction in EX
//   flush      : cancel any in-flight operation (priority over start)
//   start, op  : valid MDU instruction in EX and its operation
//   src1, src2 : rs / rt operand values
//   stallreq   : freeze IF..EX until the result is ready
//   busy       : iterations in progress
//   res_valid  : hi/lo valid for the instruction in EX
//   hi, lo     : product high/low, or remainder/quotient
module ex_mdu_ctrl
    import ex_mdu_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [StallW-1:0] stall,
    input  logic              flush,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   src1,
    input  logic [XLEN-1:0]   src2,
    output logic              stallreq,
    output logic              busy,
    output logic              res_valid,
    output logic [XLEN-1:0]   hi,
    output logic [XLEN-1:0]   lo
);

    localparam int unsigned CntW = $clog2(XLEN);

    mdu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic            dz_q, dz_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic              sgn_op;
    logic              src1_neg, src2_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              load;
    logic              step;
    logic [2*XLEN-1:0] raw;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    logic unused_stall;
    assign unused_stall = ^{stall[StallW-1:StallEx+1], stall[StallEx-1:0]};

    // Operand magnitudes; the most-negative value maps to 2^(XLEN-1), which fits unsigned.
    always_comb begin
        sgn_op   = op_is_signed(op);
        src1_neg = sgn_op & src1[XLEN-1];
        src2_neg = sgn_op & src2[XLEN-1];
        mag_a    = src1_neg ? (~src1 + 1'b1) : src1;
        mag_b    = src2_neg ? (~src2 + 1'b1) : src2;
    end

    mdu_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .is_div  (is_div_q),
        .op_a    (mag_a),
        .op_b    (mag_b),
        .acc_nxt (raw)
    );

    // Sign fix-up on the final iteration's accumulator value.
    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? (~raw + 1'b1) : raw;
        quo  = raw[XLEN-1:0];
        rem  = raw[2*XLEN-1:XLEN];
        if (neg_a_q ^ neg_b_q) begin
            quo = ~quo + 1'b1;
        end
        // Remainder follows the dividend; for divide-by-zero this reproduces src1 exactly.
        if (neg_a_q) begin
            rem = ~rem + 1'b1;
        end
        if (dz_q) begin
            quo = '1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stallreq  = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    stallreq = 1'b1;
                    load     = 1'b1;
                    is_div_d = op_is_div(op);
                    neg_a_d  = src1_neg;
                    neg_b_d  = src2_neg;
                    dz_d     = op_is_div(op) && (src2 == '0);
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                stallreq = 1'b1;
                busy     = 1'b1;
                step     = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntW'(XLEN - 1)) begin
                    if (is_div_q) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[2*XLEN-1:XLEN];
                        lo_d = prod[XLEN-1:0];
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                res_valid = 1'b1;
                // Same instruction still sits in EX while stalled; do not restart it.
                if (stall[StallEx] == NoStop) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (flush) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
